// File: rtl/serializador_pkg.sv
// serializador_pkg
//   Shared types and default constants for the serializer slice.
//   state_t        : serializer FSM states (IDLE, SHIFT, GAP)
//   WIDTH_DEF      : default parallel word width
//   GAP_CYCLES_DEF : default number of idle-level cycles after each word
//   IDLE_LEVEL_DEF : default line level when no data bit is presented
package serializador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int unsigned WIDTH_DEF      = 8;
  localparam int unsigned GAP_CYCLES_DEF = 1;
  localparam logic        IDLE_LEVEL_DEF = 1'b1;

endpackage

// File: rtl/serializador_x_contador_bits.sv
// contador_bits
//   Parameterized up-counter with synchronous clear and terminal-count flag.
//   Counts 0..MAX-1 while en=1, wrapping to 0 after MAX-1.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (count -> 0)
//   clr   : synchronous clear, has priority over en
//   en    : count enable
//   count : current count
//   tc    : high while count == MAX-1
module contador_bits
  import serializador_pkg::*;
#(
  parameter int unsigned MAX = 8,
  parameter int unsigned CW  = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  assign tc = (count == CW'(MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (tc) count <= '0;
      else    count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/serializador_x.sv
// serializador_x
//   Parallel-to-serial converter feeding a downstream sequence detector.
//   A word is accepted when valid_in & ready_out on a rising edge; its bits
//   then appear on X one per cycle, followed by GAP_CYCLES idle-level cycles.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   data_in   : parallel word (WIDTH bits)
//   valid_in  : data_in holds a valid word
//   msb_first : bit order, sampled at acceptance (1 = MSB first)
//   ready_out : block can accept a word this cycle
//   X         : serial bit stream (IDLE_LEVEL when no data bit is shown)
//   busy      : shifting or in the post-word gap
//   done      : one-cycle pulse while the last data bit is on X
module serializador_x
  import serializador_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF,
  parameter logic        IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             msb_first,
  output logic             ready_out,
  output logic             X,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BCW     = $clog2(WIDTH);
  localparam int unsigned GAP_MAX = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;
  localparam int unsigned GCW     = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] load_word;
  logic [BCW-1:0]   bit_cnt;
  logic [GCW-1:0]   gap_cnt_unused;
  logic             bit_tc, gap_tc;
  logic             accept;

  assign accept = valid_in & ready_out;

  // The shift register always shifts out of its MSB; LSB-first words are
  // bit-reversed at load time so the datapath needs no order mux on X.
  always_comb begin
    load_word = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      load_word[i] = msb_first ? data_in[i] : data_in[WIDTH-1-i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
    end else if (accept) begin
      sreg <= load_word;
    end else if (state == SHIFT) begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
    end
  end

  contador_bits #(.MAX(WIDTH), .CW(BCW)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (state == SHIFT),
    .count (bit_cnt),
    .tc    (bit_tc)
  );

  contador_bits #(.MAX(GAP_MAX), .CW(GCW)) u_gap_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != GAP),
    .en    (state == GAP),
    .count (gap_cnt_unused),
    .tc    (gap_tc)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = SHIFT;
      SHIFT: begin
        if (bit_tc) begin
          // accept is only possible here when GAP_CYCLES == 0
          if (accept)              state_nxt = SHIFT;
          else if (GAP_CYCLES > 0) state_nxt = GAP;
          else                     state_nxt = IDLE;
        end
      end
      GAP:     if (gap_tc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs, decoded from registered state only
  always_comb begin
    ready_out = (state == IDLE) ||
                ((GAP_CYCLES == 0) && (state == SHIFT) && bit_tc);
    busy      = (state == SHIFT) || (state == GAP);
    done      = (state == SHIFT) && (bit_cnt == BCW'(WIDTH - 1));
    X         = (state == SHIFT) ? sreg[WIDTH-1] : IDLE_LEVEL;
  end

endmodule

// File: tb/tb_serializador_x.sv
module tb_serializador_x;

  localparam int   W  = 8;
  localparam int   G  = 1;
  localparam logic IL = 1'b1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] data_in, d0;
  logic         valid_in, v0, msb_first, m0;
  logic         ready_out, X, busy, done;
  logic         ready0, X0, busy0, done0;

  always #5 clk = ~clk;

  serializador_x #(.WIDTH(W), .GAP_CYCLES(G), .IDLE_LEVEL(IL)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .msb_first(msb_first), .ready_out(ready_out), .X(X), .busy(busy), .done(done)
  );

  serializador_x #(.WIDTH(W), .GAP_CYCLES(0), .IDLE_LEVEL(IL)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(d0), .valid_in(v0),
    .msb_first(m0), .ready_out(ready0), .X(X0), .busy(busy0), .done(done0)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: expected serial bits are queued at acceptance, popped per data cycle
  bit q[$];
  int bits_left = 0;
  int gap_left  = 0;
  bit chk_en    = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      bits_left <= 0;
      gap_left  <= 0;
    end else if (bits_left > 0) begin
      bits_left <= bits_left - 1;
      if (bits_left == 1) gap_left <= G;
    end else if (gap_left > 0) begin
      gap_left <= gap_left - 1;
    end else if (valid_in) begin
      bits_left <= W;
      for (int i = 0; i < W; i++) q.push_back(msb_first ? data_in[W-1-i] : data_in[i]);
    end
  end

  // Downstream detector for "1011" (overlapping), fed by the DUT's X
  typedef enum logic [1:0] {S0, S1, S10, S101} dstate_t;
  dstate_t      dst = S0;
  logic [3:0]   hist = '0;

  always @(negedge clk) begin : mon
    logic ex, ed, eb, er, y_dut, y_mod;
    if (!chk_en) begin
      dst  <= S0;
      hist <= '0;
    end else begin
      ex = IL; ed = 1'b0; eb = 1'b0; er = 1'b1;
      if (bits_left > 0) begin
        if (q.size() == 0) chk("sb_underflow", 32'(q.size()), 32'd1);
        else ex = q.pop_front();
        ed = (bits_left == 1); eb = 1'b1; er = 1'b0;
      end else if (gap_left > 0) begin
        eb = 1'b1; er = 1'b0;
      end
      chk("sb_x",     32'(X),         32'(ex));
      chk("sb_done",  32'(done),      32'(ed));
      chk("sb_busy",  32'(busy),      32'(eb));
      chk("sb_ready", 32'(ready_out), 32'(er));
      y_dut = (dst == S101) && X;
      y_mod = ({hist[2:0], ex} == 4'b1011);
      chk("det_y", 32'(y_dut), 32'(y_mod));
      hist <= {hist[2:0], ex};
      case (dst)
        S0:      dst <= X ? S1   : S0;
        S1:      dst <= X ? S1   : S10;
        S10:     dst <= X ? S101 : S0;
        default: dst <= X ? S1   : S10;
      endcase
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Holds valid until the DUT is ready; returns in the first data cycle
  task automatic offer(input logic [W-1:0] d, input logic m);
    bit ok;
    ok = 0;
    data_in = d; msb_first = m; valid_in = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (ready_out) begin ok = 1; break; end
      step();
    end
    if (!ok) chk("offer_timeout", 32'(ready_out), 32'd1);
    step();
    valid_in  = 1'b0;
    data_in   = W'($urandom);
    msb_first = 1'($urandom);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      if (ready_out) begin ok = 1; break; end
      step();
    end
    if (!ok) chk("idle_timeout", 32'(ready_out), 32'd1);
  endtask

  logic [W-1:0]   v;
  logic [17:0]    s;
  logic [2*W-1:0] t;

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; data_in = '0; msb_first = 1'b1;
    v0 = 1'b0; d0 = '0; m0 = 1'b1;
    #1;
    chk("rst_x",      32'(X),         32'(IL));
    chk("rst_busy",   32'(busy),      32'd0);
    chk("rst_done",   32'(done),      32'd0);
    chk("rst_ready",  32'(ready_out), 32'd1);
    chk("rst0_x",     32'(X0),        32'(IL));
    chk("rst0_ready", 32'(ready0),    32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_en = 1;

    // MSB-first A5, accepted on the first edge after reset release
    offer(8'hA5, 1'b1);
    for (int i = 0; i < W; i++) begin
      v[W-1-i] = X;
      chk("a5_done", 32'(done), 32'(i == W-1));
      step();
    end
    chk("a5_stream", 32'(v), 32'h0000_00A5);
    chk("a5_gap_x",    32'(X),    32'd1);
    chk("a5_gap_busy", 32'(busy), 32'd1);
    step();
    chk("a5_ready", 32'(ready_out), 32'd1);

    // LSB-first 01 with inputs disturbed during the shift
    offer(8'h01, 1'b0);
    for (int i = 0; i < W; i++) begin
      v[i] = X;
      data_in = 8'hFF; msb_first = ~msb_first; valid_in = (i < W-1);
      step();
    end
    chk("lsb_stream", 32'(v), 32'h0000_0001);

    // valid held high: 0F then F0, one gap plus one idle cycle between
    wait_idle();
    data_in = 8'h0F; msb_first = 1'b1; valid_in = 1'b1;
    step();
    data_in = 8'hF0;
    for (int i = 0; i < 18; i++) begin
      s[17-i] = X;
      if (i == 9) chk("b2b_idle_busy", 32'(busy), 32'd0);
      if (i == 10) valid_in = 1'b0;
      step();
    end
    chk("b2b_stream", 32'(s), 32'({8'h0F, 2'b11, 8'hF0}));

    // GAP_CYCLES=0 instance: FF then 00 gapless
    d0 = 8'hFF; m0 = 1'b1; v0 = 1'b1;
    step();
    d0 = 8'h00;
    for (int i = 0; i < 2*W; i++) begin
      t[2*W-1-i] = X0;
      chk("g0_done", 32'(done0), 32'((i == W-1) || (i == 2*W-1)));
      chk("g0_busy", 32'(busy0), 32'd1);
      if (i == W) v0 = 1'b0;
      step();
    end
    chk("g0_stream", 32'(t), 32'h0000_FF00);
    chk("g0_end_busy",  32'(busy0),  32'd0);
    chk("g0_end_ready", 32'(ready0), 32'd1);
    chk("g0_end_x",     32'(X0),     32'(IL));

    // Reset during bit 3 of AA
    wait_idle();
    offer(8'hAA, 1'b1);
    step(); step(); step();
    chk_en = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_x",     32'(X),         32'(IL));
    chk("arst_busy",  32'(busy),      32'd0);
    chk("arst_ready", 32'(ready_out), 32'd1);
    chk("arst_done",  32'(done),      32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 chk_en = 1;
    offer(8'h3C, 1'b1);
    for (int i = 0; i < W; i++) begin
      v[W-1-i] = X;
      step();
    end
    chk("post_rst_stream", 32'(v), 32'h0000_003C);

    // Random traffic checked by the scoreboard and detector model
    for (int w = 0; w < 200; w++) begin
      int idle_n;
      idle_n = int'($urandom_range(0, 2));
      for (int k = 0; k < idle_n; k++) begin
        data_in = W'($urandom); msb_first = 1'($urandom);
        step();
      end
      offer(W'($urandom), 1'($urandom_range(0, 1)));
    end
    wait_idle();
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serializador_x.md
SERIALIZADOR_X -- requirements
Module: serializador_x

Interface
REQ-001 Parameter WIDTH, default 8, number of bits in each parallel word (min 2).
REQ-002 Parameter GAP_CYCLES, default 1, idle-level cycles inserted after each word (0..15).
REQ-003 Parameter IDLE_LEVEL, default 1'b1, value driven on X whenever no data bit is being presented.
REQ-004 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port data_in  input  WIDTH  parallel word to serialize.
REQ-007 Port valid_in  input  1  data_in holds a valid word.
REQ-008 Port msb_first  input  1  bit order of the word; 1 = MSB first, 0 = LSB first.
REQ-009 Port ready_out  output  1  block accepts a word this cycle.
REQ-010 Port X  output  1  registered serial bit stream feeding the downstream sequence-detector FSM input X.
REQ-011 Port busy  output  1  a word is being shifted or a gap is in progress.
REQ-012 Port done  output  1  one-cycle pulse marking the last data bit of a word.

Function
REQ-013 FSM states: IDLE, SHIFT, GAP; encoding comes from the package.
REQ-014 Handshake: a word is accepted on a rising edge where valid_in=1 and ready_out=1; data_in and msb_first are captured into a shift register at that edge.
REQ-015 ready_out = 1 in IDLE; 0 in SHIFT and GAP, except as stated in REQ-021.
REQ-016 Latency: the first data bit appears on X in the cycle immediately after acceptance; each bit is held for exactly one cycle; WIDTH consecutive cycles carry data.
REQ-017 msb_first is sampled only at acceptance; changes to it, data_in or valid_in while busy=1 have no effect.
REQ-018 The bit counter runs 0..WIDTH-1, sized $clog2(WIDTH); done = 1 exactly in the cycle the bit with count WIDTH-1 is on X.
REQ-019 Transitions:
- IDLE->SHIFT on acceptance.
- SHIFT->GAP after the last bit when GAP_CYCLES>0.
- GAP->IDLE after GAP_CYCLES cycles with X=IDLE_LEVEL.
REQ-020 X = IDLE_LEVEL in IDLE and GAP; busy = 1 in SHIFT and GAP.
REQ-021 When GAP_CYCLES=0, ready_out is also 1 during the last SHIFT cycle. Acceptance in that cycle reloads the register and stays in SHIFT, giving gapless back-to-back words. Without acceptance in that cycle, the FSM goes SHIFT->IDLE.
REQ-022 All outputs are registered or decoded from registered state only; no combinational path from data_in to X.

Reset
REQ-023 rst_n=0 forces, without waiting for clk:
- state = IDLE
- counter = 0
- shift register = 0
- X = IDLE_LEVEL
- busy = 0, done = 0, ready_out = 1
REQ-024 Reset asserted mid-word aborts the word; no partial bits are emitted after rst_n returns high.
REQ-025 The first acceptance is possible on the first rising edge after rst_n deasserts.

Structure
REQ-026 Package serializador_pkg holds the state enum (IDLE, SHIFT, GAP) and the default constants for WIDTH, GAP_CYCLES and IDLE_LEVEL.
REQ-027 One sub-module, contador_bits, a parameterized up-counter with clear and terminal-count flag, is used for both the bit count and the gap count.

Verification
REQ-028 WIDTH=8, msb_first=1, accept 8'hA5 -> X = 1,0,1,0,0,1,0,1 on cycles 1..8 after acceptance; done high on cycle 8 only; X=1 and busy=1 on cycle 9; ready_out=1 on cycle 10.
REQ-029 msb_first=0, accept 8'h01 -> X = 1,0,0,0,0,0,0,0; data_in changed to 8'hFF and msb_first toggled during the shift -> stream unchanged.
REQ-030 valid_in held high continuously with GAP_CYCLES=1, words 8'h0F then 8'hF0 -> exactly one IDLE_LEVEL gap cycle plus one IDLE cycle between words; no word lost or duplicated.
REQ-031 GAP_CYCLES=0, words 8'hFF then 8'h00 offered back-to-back -> 16 contiguous data cycles; done pulses on cycles 8 and 16.
REQ-032 rst_n pulled low during bit 3 of 8'hAA -> X=IDLE_LEVEL, busy=0, ready_out=1 immediately (asynchronously); after release, the next word serializes correctly from bit 0.
REQ-033 Integration: output X drives the downstream detector FSM; a scoreboard models that FSM and checks its output Y cycle-by-cycle for 200 random words.
